// File: rtl/uio_alu_pkg.sv
// Shared definitions for the uio ALU sequencer: op codes, FSM states, default width.
package uio_alu_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_TURN    = 3'd2,
        S_DRIVE   = 3'd3,
        S_RELEASE = 3'd4
    } state_e;

endpackage

// File: rtl/uio_alu_core.sv
// Combinational ALU: XOR/AND/OR/ADD on two WIDTH-bit operands; carry only for ADD.
module uio_alu_core
    import uio_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    // Select the operation; carry is forced low for the logic ops.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/uio_alu_sequencer.sv
// Sequencer for the 8-bit pin datapath: captures operands, computes the result,
// then walks the shared uio bus through release -> drive -> release so the bus
// is only ever driven inside the DRIVE window. Every output is a flop.
module uio_alu_sequencer
    import uio_alu_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TURN_CYCLES = 1,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] bus_in_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic [WIDTH-1:0] bus_out_o,
    output logic [WIDTH-1:0] bus_oe_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             drop_o
);

    // One down-counter serves both TURN and DRIVE; it is loaded with N-1 on
    // entry and the state exits on the edge where it reads zero.
    localparam int CNT_MAX   = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TURN_LOAD = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
    localparam int HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    state_e           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [1:0]       op_q, op_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] result_n;
    logic             carry_n;
    logic [WIDTH-1:0] bus_out_n;
    logic [WIDTH-1:0] bus_oe_n;
    logic             busy_n;
    logic             done_n;
    logic             drop_n;

    logic [WIDTH-1:0] core_result;
    logic             core_carry;

    uio_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result),
        .carry  (core_carry)
    );

    // State and output registers; ena=0 freezes everything, reset releases the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_o  <= '0;
            carry_o   <= 1'b0;
            bus_out_o <= '0;
            bus_oe_o  <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            drop_o    <= 1'b0;
        end else if (ena) begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            op_q      <= op_n;
            a_q       <= a_n;
            b_q       <= b_n;
            result_o  <= result_n;
            carry_o   <= carry_n;
            bus_out_o <= bus_out_n;
            bus_oe_o  <= bus_oe_n;
            busy_o    <= busy_n;
            done_o    <= done_n;
            drop_o    <= drop_n;
        end
    end

    // Next-state and next-output decode; everything holds unless a state changes it.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        op_n      = op_q;
        a_n       = a_q;
        b_n       = b_q;
        result_n  = result_o;
        carry_n   = carry_o;
        bus_out_n = bus_out_o;
        bus_oe_n  = bus_oe_o;
        busy_n    = busy_o;
        done_n    = done_o;
        drop_n    = drop_o;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_n    = op_i;
                    a_n     = a_i;
                    b_n     = bus_in_i;
                    busy_n  = 1'b1;
                    drop_n  = 1'b0;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                result_n = core_result;
                carry_n  = core_carry;
                if (TURN_CYCLES == 0) begin
                    // No turnaround: the result goes straight onto the bus,
                    // so take it from the core rather than the stale register.
                    bus_oe_n  = '1;
                    bus_out_n = core_result;
                    cnt_n     = CNT_W'(HOLD_LOAD);
                    state_n   = S_DRIVE;
                end else begin
                    cnt_n   = CNT_W'(TURN_LOAD);
                    state_n = S_TURN;
                end
            end
            S_TURN: begin
                if (cnt_q == '0) begin
                    bus_oe_n  = '1;
                    bus_out_n = result_o;
                    cnt_n     = CNT_W'(HOLD_LOAD);
                    state_n   = S_DRIVE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    bus_oe_n  = '0;
                    bus_out_n = '0;
                    done_n    = 1'b1;
                    state_n   = S_RELEASE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_RELEASE: begin
                done_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                bus_oe_n  = '0;
                bus_out_n = '0;
                busy_n    = 1'b0;
                done_n    = 1'b0;
                state_n   = S_IDLE;
            end
        endcase

        // Requests are only accepted from IDLE; anything else is flagged as dropped.
        if (start_i && (state_q != S_IDLE))
            drop_n = 1'b1;
    end

endmodule
